// File: rtl/alu_decode_stage.sv
// RV32I decode stage: valid/ready in from fetch, registered ALU packet out to execute.
// Optional DECODE_ILLEGAL_CNT_EN adds a saturating count of consumed illegal packets.
module alu_decode_stage #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] oper1_o,
  output logic [XLEN-1:0] oper2_o,
  output logic [OP_W-1:0] sel_op_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_we_o,
  output logic            illegal_o
`ifdef DECODE_ILLEGAL_CNT_EN
  ,
  output logic [15:0]     illegal_cnt_o
`endif
);

  localparam logic [OP_W-1:0] ALU_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] ALU_SLL  = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_SLT  = OP_W'(2);
  localparam logic [OP_W-1:0] ALU_SLTU = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_XOR  = OP_W'(4);

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] o1;
    logic [XLEN-1:0] o2;
    logic [4:0]      rd;
    logic            we;
    logic            ill;
  } ex_pkt_t;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_u;
  logic            legal;
  ex_pkt_t         dec, pkt;
  logic            vld;
  logic            accept;

  assign opcode     = instr_i[6:0];
  assign f3         = instr_i[14:12];
  assign f7         = instr_i[31:25];
  assign imm_i      = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_u      = {instr_i[31:12], 12'b0};
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  assign instr_ready_o = !vld || ex_ready_i;
  assign accept        = instr_valid_i && instr_ready_o;

  // Illegal encodings leave the defaults in place: ADD with zero operands.
  always_comb begin
    legal  = 1'b0;
    dec    = '0;
    dec.op = ALU_ADD;
    unique case (opcode)
      OPC_OPIMM: begin
        dec.o1 = rs1_data_i;
        dec.o2 = imm_i;
        unique case (f3)
          3'b000: begin legal = 1'b1; dec.op = ALU_ADD;  end
          3'b010: begin legal = 1'b1; dec.op = ALU_SLT;  end
          3'b011: begin legal = 1'b1; dec.op = ALU_SLTU; end
          3'b100: begin legal = 1'b1; dec.op = ALU_XOR;  end
          3'b001: begin
            legal  = (f7 == 7'b0);
            dec.op = ALU_SLL;
            dec.o2 = {{(XLEN-5){1'b0}}, instr_i[24:20]};
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP: begin
        dec.o1 = rs1_data_i;
        dec.o2 = rs2_data_i;
        unique case (f3)
          3'b000: begin legal = (f7 == 7'b0); dec.op = ALU_ADD;  end
          3'b001: begin legal = (f7 == 7'b0); dec.op = ALU_SLL;  end
          3'b010: begin legal = (f7 == 7'b0); dec.op = ALU_SLT;  end
          3'b011: begin legal = (f7 == 7'b0); dec.op = ALU_SLTU; end
          3'b100: begin legal = (f7 == 7'b0); dec.op = ALU_XOR;  end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        legal  = 1'b1;
        dec.o2 = imm_u;
      end
      OPC_AUIPC: begin
        legal  = 1'b1;
        dec.o1 = pc_i;
        dec.o2 = imm_u;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.op = ALU_ADD;
      dec.o1 = '0;
      dec.o2 = '0;
    end
    dec.rd  = instr_i[11:7];
    dec.we  = legal && (instr_i[11:7] != 5'd0);
    dec.ill = !legal;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld    <= 1'b0;
      pkt    <= '0;
      pkt.op <= ALU_ADD;
    end else if (flush_i) begin
      vld <= 1'b0;
    end else if (accept) begin
      vld <= 1'b1;
      pkt <= dec;
    end else if (ex_ready_i) begin
      vld <= 1'b0;
    end
  end

  assign ex_valid_o = vld;
  assign oper1_o    = pkt.o1;
  assign oper2_o    = pkt.o2;
  assign sel_op_o   = pkt.op;
  assign rd_addr_o  = pkt.rd;
  assign rd_we_o    = pkt.we;
  assign illegal_o  = pkt.ill;

`ifdef DECODE_ILLEGAL_CNT_EN
  logic [15:0] ill_cnt;

  // A packet killed by a same-cycle flush never counts as consumed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      ill_cnt <= '0;
    else if (vld && ex_ready_i && !flush_i && pkt.ill && (ill_cnt != 16'hFFFF))
      ill_cnt <= ill_cnt + 16'd1;
  end

  assign illegal_cnt_o = ill_cnt;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode table, stall, flush and async reset.
module tb_alu_decode_stage;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SLL  = 5'd1;
  localparam logic [4:0] ALU_SLT  = 5'd2;
  localparam logic [4:0] ALU_SLTU = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic        flush_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [31:0] oper1_o, oper2_o;
  logic [4:0]  sel_op_o, rd_addr_o;
  logic        rd_we_o, illegal_o;
`ifdef DECODE_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt_o;
`endif

  alu_decode_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .oper1_o(oper1_o), .oper2_o(oper2_o), .sel_op_o(sel_op_o),
    .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .illegal_o(illegal_o)
`ifdef DECODE_ILLEGAL_CNT_EN
    , .illegal_cnt_o(illegal_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] instr, pc, rs1, rs2;
    logic [4:0]  op;
    logic [31:0] o1, o2;
    logic [4:0]  rd;
    logic        we, ill;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_pkt(input vec_t v);
    chk({v.name, ".valid"}, 32'(ex_valid_o), 32'd1);
    chk({v.name, ".op"},    32'(sel_op_o),   32'(v.op));
    chk({v.name, ".oper1"}, oper1_o,         v.o1);
    chk({v.name, ".oper2"}, oper2_o,         v.o2);
    chk({v.name, ".rd"},    32'(rd_addr_o),  32'(v.rd));
    chk({v.name, ".we"},    32'(rd_we_o),    32'(v.we));
    chk({v.name, ".ill"},   32'(illegal_o),  32'(v.ill));
  endtask

  task automatic drive(input vec_t v);
    instr_valid_i = 1'b1;
    instr_i       = v.instr;
    pc_i          = v.pc;
    rs1_data_i    = v.rs1;
    rs2_data_i    = v.rs2;
  endtask

  task automatic add(input string n, input logic [31:0] instr, pc, rs1, rs2,
                     input logic [4:0] op, input logic [31:0] o1, o2,
                     input logic [4:0] rd, input logic we, ill);
    vec_t v;
    v.name = n; v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.op = op; v.o1 = o1; v.o2 = o2; v.rd = rd; v.we = we; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vec_t slt_v, addi_v;
    int   n_ill;

    //   name     instr         pc           rs1          rs2          op        oper1        oper2        rd  we ill
    add("addi",  32'hFFD08293, 32'h0,       32'd10,      32'd0,       ALU_ADD,  32'd10,      32'hFFFFFFFD, 5,  1, 0);
    add("slt",   32'h002021B3, 32'h0,       32'd5,       32'd7,       ALU_SLT,  32'd5,       32'd7,        3,  1, 0);
    add("auipc", 32'h12345397, 32'h100,     32'h0,       32'h0,       ALU_ADD,  32'h100,     32'h12345000, 7,  1, 0);
    add("lui_x0",32'h00001037, 32'h0,       32'h55,      32'h66,      ALU_ADD,  32'h0,       32'h1000,     0,  0, 0);
    add("sub",   32'h403100B3, 32'h0,       32'h11,      32'h22,      ALU_ADD,  32'h0,       32'h0,        1,  0, 1);
    add("slli_b",32'h02409113, 32'h0,       32'hAA,      32'h0,       ALU_ADD,  32'h0,       32'h0,        2,  0, 1);
    add("slli",  32'h00409113, 32'h0,       32'hAA,      32'h0,       ALU_SLL,  32'hAA,      32'd4,        2,  1, 0);
    add("xori",  32'h7FF0C213, 32'h0,       32'h1234,    32'h0,       ALU_XOR,  32'h1234,    32'h7FF,      4,  1, 0);
    add("sltiu", 32'hFFF0B313, 32'h0,       32'h9,       32'h0,       ALU_SLTU, 32'h9,       32'hFFFFFFFF, 6,  1, 0);
    add("xor",   32'h0020C433, 32'h0,       32'hF0F0,    32'h0FF0,    ALU_XOR,  32'hF0F0,    32'h0FF0,     8,  1, 0);
    add("add",   32'h002084B3, 32'h0,       32'h3,       32'h4,       ALU_ADD,  32'h3,       32'h4,        9,  1, 0);
    add("lw",    32'h00012083, 32'h0,       32'h7,       32'h8,       ALU_ADD,  32'h0,       32'h0,        1,  0, 1);

    rst_i = 1'b1; instr_valid_i = 1'b0; instr_i = '0; pc_i = '0;
    rs1_data_i = '0; rs2_data_i = '0; flush_i = 1'b0; ex_ready_i = 1'b1;
    step();
    chk("rst.valid", 32'(ex_valid_o), 32'd0);
    chk("rst.op",    32'(sel_op_o),   32'(ALU_ADD));
    chk("rst.oper1", oper1_o, 32'd0);
    chk("rst.oper2", oper2_o, 32'd0);
    chk("rst.rd",    32'(rd_addr_o), 32'd0);
    chk("rst.we",    32'(rd_we_o),   32'd0);
    chk("rst.ill",   32'(illegal_o), 32'd0);
    chk("rst.ready", 32'(instr_ready_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    step();

    // Back-to-back table stream with execute always ready: one packet per cycle.
    n_ill = 0;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk({vecs[i].name, ".rs1a"}, 32'(rs1_addr_o), 32'(vecs[i].instr[19:15]));
      chk({vecs[i].name, ".rs2a"}, 32'(rs2_addr_o), 32'(vecs[i].instr[24:20]));
      chk({vecs[i].name, ".rdy"},  32'(instr_ready_o), 32'd1);
      step();
      chk_pkt(vecs[i]);
      if (vecs[i].ill) n_ill++;
    end
    instr_valid_i = 1'b0;
    step();
    chk("drain.valid", 32'(ex_valid_o), 32'd0);
`ifdef DECODE_ILLEGAL_CNT_EN
    chk("ill_cnt", 32'(illegal_cnt_o), 32'(n_ill));
`endif

    // Stall: SLT held for 3 cycles while ADDI waits at the input.
    slt_v  = vecs[1];
    addi_v = vecs[0];
    ex_ready_i = 1'b0;
    drive(slt_v);
    step();
    chk_pkt(slt_v);
    drive(addi_v);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall.ready", 32'(instr_ready_o), 32'd0);
      chk_pkt(slt_v);
    end
    ex_ready_i = 1'b1;
    #1;
    chk("unstall.ready", 32'(instr_ready_o), 32'd1);
    step();
    chk_pkt(addi_v);

    // Flush on the 3rd of 4 streamed accepts.
    for (int k = 0; k < 4; k++) begin
      drive(vecs[6 + k]);
      flush_i = (k == 2);
      step();
      if (k == 2) chk("flush.valid", 32'(ex_valid_o), 32'd0);
      else        chk_pkt(vecs[6 + k]);
    end
    flush_i = 1'b0;
    instr_valid_i = 1'b0;
    step();
    chk("post_flush.valid", 32'(ex_valid_o), 32'd0);

    // Async reset while a packet is stalled.
    ex_ready_i = 1'b0;
    drive(vecs[2]);
    step();
    chk_pkt(vecs[2]);
    instr_valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst.valid", 32'(ex_valid_o), 32'd0);
    chk("arst.oper1", oper1_o, 32'd0);
    chk("arst.oper2", oper2_o, 32'd0);
    chk("arst.rd",    32'(rd_addr_o), 32'd0);
    chk("arst.we",    32'(rd_we_o),   32'd0);
    chk("arst.ready", 32'(instr_ready_o), 32'd1);
`ifdef DECODE_ILLEGAL_CNT_EN
    chk("arst.cnt",   32'(illegal_cnt_o), 32'd0);
`endif
    step();
    rst_i = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
